// File: rtl/uart_tx_if.sv
// uart_tx_if: host-side request/status handshake of the UART transmitter
interface uart_tx_if;
  logic       tx_start_i;
  logic [7:0] din_i;
  logic       tx_busy_o;
  logic       tx_done_tick_o;
  modport master (output tx_start_i, din_i, input tx_busy_o, tx_done_tick_o);
  modport slave (input tx_start_i, din_i, output tx_busy_o, tx_done_tick_o);
endinterface

// File: rtl/uart_tx.sv
// uart_tx: 16x-tick UART transmitter, start + WordLength data bits LSB first + 1/1.5/2 stop bits
module uart_tx #(
  parameter int WordLength   = 8,
  parameter int StopBitTicks = 16
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  input  logic     sample_tick_i,
  uart_tx_if.slave bus,
  output logic     tx_o
);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  localparam logic [4:0] StopLast = 5'(StopBitTicks - 1);
  localparam logic [2:0] BitLast  = 3'(WordLength - 1);
  state_t     state_q, state_d;
  logic [4:0] tick_q, tick_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d;
  logic       tx_d, done;
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    done    = 1'b0;
    case (state_q)
      IDLE: if (bus.tx_start_i) begin
        state_d = START;
        tick_d  = '0;
        shift_d = bus.din_i;
      end
      START: if (sample_tick_i) begin
        tick_d = tick_q + 5'd1;
        if (tick_q == 5'd15) begin
          tick_d  = '0;
          bit_d   = '0;
          state_d = DATA;
        end
      end
      DATA: if (sample_tick_i) begin
        tick_d = tick_q + 5'd1;
        if (tick_q == 5'd15) begin
          tick_d  = '0;
          shift_d = shift_q >> 1;
          if (bit_q == BitLast) state_d = STOP;
          else bit_d = bit_q + 3'd1;
        end
      end
      STOP: if (sample_tick_i) begin
        tick_d = tick_q + 5'd1;
        if (tick_q == StopLast) begin
          state_d = IDLE;
          done    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // line value follows the next state so the pin flop changes with the state
    tx_d = (state_d == START) ? 1'b0 : (state_d == DATA) ? shift_d[0] : 1'b1;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_o    <= 1'b1;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_o    <= tx_d;
    end
  end
  assign bus.tx_busy_o      = state_q != IDLE;
  assign bus.tx_done_tick_o = done;
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: four parameter variants driven together, checked against a tick-position frame model
module tb_uart_tx;
  logic       clk = 1'b0, rst_n = 1'b0, tick = 1'b0, tx_start = 1'b0;
  logic [7:0] din = 8'h00;
  int         tick_per = 10, errors = 0, checks = 0;
  logic [3:0] tx_w, busy_w, done_w, exp_tx, exp_busy, exp_done;
  int         len_lit [4] = '{160, 168, 176, 112};
  int         wl [4] = '{8, 8, 8, 5};
  int         frame_ticks [4] = '{0, 0, 0, 0};
  int         done_cnt [4] = '{0, 0, 0, 0};
  logic [7:0] cap [4];
  always #5 clk = ~clk;
  function automatic logic bit_at(input int w, input logic [7:0] word, input int pos);
    if (pos < 16) return 1'b0;
    if (pos < 16 * (1 + w)) return word[3'((pos - 16) / 16)];
    return 1'b1;
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  for (genvar g = 0; g < 4; g++) begin : u
    localparam int W = (g == 3) ? 5 : 8;
    localparam int S = (g == 1) ? 24 : (g == 2) ? 32 : 16;
    localparam int L = (1 + W) * 16 + S;
    uart_tx_if bus ();
    logic       m_busy;
    int         m_pos;
    logic [7:0] m_word;
    assign bus.tx_start_i = tx_start;
    assign bus.din_i      = din;
    uart_tx #(.WordLength(W), .StopBitTicks(S)) dut (
      .clk_i(clk), .rst_ni(rst_n), .sample_tick_i(tick), .bus(bus), .tx_o(tx_w[g]));
    assign busy_w[g] = bus.tx_busy_o;
    assign done_w[g] = bus.tx_done_tick_o;
    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        m_busy <= 1'b0;
        m_pos  <= 0;
        m_word <= 8'h00;
      end else if (!m_busy) begin
        if (tx_start) begin
          m_busy <= 1'b1;
          m_pos  <= 0;
          m_word <= din;
        end
      end else if (tick) begin
        if (m_pos == L - 1) m_busy <= 1'b0;
        else m_pos <= m_pos + 1;
      end
    end
    assign exp_tx[g]   = m_busy ? bit_at(W, m_word, m_pos) : 1'b1;
    assign exp_busy[g] = m_busy;
    assign exp_done[g] = m_busy && tick && (m_pos == L - 1);
  end
  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("tx%0d", k), 32'(tx_w[k]), 32'(exp_tx[k]));
      chk($sformatf("busy%0d", k), 32'(busy_w[k]), 32'(exp_busy[k]));
      chk($sformatf("done%0d", k), 32'(done_w[k]), 32'(exp_done[k]));
      if (!rst_n) frame_ticks[k] = 0;
      else begin
        if (busy_w[k] && tick) begin
          if (frame_ticks[k] == 0) cap[k] = 8'h00;
          if (frame_ticks[k] % 16 == 8 && frame_ticks[k] >= 24 && frame_ticks[k] < 16 * (wl[k] + 1))
            cap[k][3'((frame_ticks[k] - 24) / 16)] = tx_w[k];
          frame_ticks[k]++;
        end
        if (done_w[k]) begin
          chk($sformatf("frame_len%0d", k), 32'(frame_ticks[k]), 32'(len_lit[k]));
          done_cnt[k]++;
          frame_ticks[k] = 0;
        end
      end
    end
  end
  initial begin
    int tc;
    tc = 0;
    forever begin
      @(posedge clk);
      #1;
      if (tick_per == 0) tick = ($urandom_range(0, 3) == 0);
      else if (tick_per == 1) tick = 1'b1;
      else begin
        tick = (tc == 0);
        tc = (tc + 1) % tick_per;
      end
    end
  end
  task automatic send(input logic [7:0] d);
    @(posedge clk);
    #1;
    tx_start = 1'b1;
    din = d;
    @(posedge clk);
    #1;
    tx_start = 1'b0;
  endtask
  task automatic wait_done(input int k, input int max);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < max && !seen; i++) begin
      @(negedge clk);
      seen = done_w[k];
    end
    chk("done_timeout", 32'(seen), 32'd1);
  endtask
  task automatic wait_idle(input int max);
    logic idle;
    idle = 1'b0;
    for (int i = 0; i < max && !idle; i++) begin
      @(negedge clk);
      idle = (busy_w == 4'h0);
    end
    chk("idle_timeout", 32'(idle), 32'd1);
  endtask
  initial begin
    int d0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    send(8'h5A);
    repeat (400) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("rst_tx", 32'(tx_w), 32'hF);
    chk("rst_busy", 32'(busy_w), 32'h0);
    chk("rst_done", 32'(done_w), 32'h0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (300) @(negedge clk);
    chk("idle_tx", 32'(tx_w), 32'hF);
    chk("no_done_after_rst", 32'(done_cnt[0]), 32'd0);
    send(8'hA5);
    wait_done(0, 3000);
    chk("cap_a5", 32'(cap[0]), 32'hA5);
    wait_idle(5000);
    send(8'h00);
    wait_idle(5000);
    chk("cap_00_stop24", 32'(cap[1]), 32'h00);
    send(8'hFF);
    wait_idle(5000);
    chk("cap_ff_w5", 32'(cap[3]), 32'h1F);
    chk("cap_ff_w8", 32'(cap[0]), 32'hFF);
    d0 = done_cnt[0];
    send(8'h3C);
    repeat (300) @(posedge clk);
    send(8'hFF);
    wait_idle(5000);
    chk("cap_busy_reject", 32'(cap[0]), 32'h3C);
    chk("one_done", 32'(done_cnt[0] - d0), 32'd1);
    repeat (100) @(negedge clk);
    chk("no_second_frame", 32'(busy_w), 32'h0);
    tick_per = 1;
    @(posedge clk);
    #1;
    tx_start = 1'b1;
    din = 8'h81;
    wait_done(0, 400);
    @(negedge clk);
    chk("bb_gap_busy", 32'(busy_w[0]), 32'd0);
    @(negedge clk);
    chk("bb_restart_busy", 32'(busy_w[0]), 32'd1);
    chk("bb_restart_tx", 32'(tx_w[0]), 32'd0);
    wait_done(0, 400);
    chk("cap_81", 32'(cap[0]), 32'h81);
    @(posedge clk);
    #1 tx_start = 1'b0;
    wait_idle(1000);
    for (int i = 0; i < 20000; i++) begin
      @(posedge clk);
      #1;
      if (i % 2000 == 0) tick_per = $urandom_range(0, 3);
      tx_start = ($urandom_range(0, 199) == 0);
      din = 8'($urandom);
      rst_n = ($urandom_range(0, 4999) != 0);
    end
    rst_n = 1'b1;
    tx_start = 1'b0;
    tick_per = 1;
    wait_idle(1000);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
UART transmitter, the transmit counterpart of the team's 16x-oversampled receiver. It serialises one parallel word per request into a frame: start bit (0), WordLength data bits LSB first, no parity, then 1, 1.5 or 2 stop bits (1). Bit timing comes from the shared baud generator's sample_tick_i, 16 ticks per bit. The block sits between the host-side register/FIFO logic and the tx pin.

Parameters:
WordLength, 8, data bits per frame; legal 5..8.
StopBitTicks, 16, stop-bit duration in sample ticks; 16 = 1 stop bit, 24 = 1.5, 32 = 2; other values illegal.

Ports:
clk_i  input  1  clock; all logic on rising edge.
rst_ni  input  1  asynchronous active-low reset.
sample_tick_i  input  1  one-cycle enable from the baud generator, 16 per bit period.
tx_start_i  input  1  transmit request; sampled only in IDLE.
din_i  input  8  word to send; bits [WordLength-1:0] used, upper bits ignored.
tx_o  output  1  serial line, registered, idles high.
tx_busy_o  output  1  high whenever state != IDLE.
tx_done_tick_o  output  1  one-cycle pulse at frame end.

Behaviour:
- Reset (rst_ni=0, async): state IDLE, tx_o=1, tx_busy_o=0, tx_done_tick_o=0, tick counter, bit counter and shift register = 0. Reset mid-frame aborts the frame; tx_o goes high immediately, no done pulse.
- tx_o comes from a flop (no combinational glitches). Counters: 5-bit tick counter (reaches 31), 3-bit bit counter, 8-bit shift register.
- IDLE: tx_o=1. If tx_start_i=1, latch din_i into the shift register, clear the tick counter and go to START. tx_o=0 and tx_busy_o=1 from the next cycle, so latency is 1 clock from request to start-bit edge. tx_start_i does not need sample_tick_i alignment.
- START: tx_o=0. On each sample_tick_i, increment the tick counter. On the tick where counter==15, clear the counter and bit counter and go to DATA.
- DATA: tx_o = shift[0]. On each tick, increment the counter. When counter==15: clear it, shift right by 1, and then:
  - if bit counter == WordLength-1, go to STOP;
  - otherwise increment the bit counter.
- STOP: tx_o=1. On each tick, increment the counter. When counter==StopBitTicks-1, go to IDLE and assert tx_done_tick_o for that single clock (combinational from state/tick, same cycle as the transition). tx_busy_o falls the following cycle.
- Each start and data bit lasts exactly 16 ticks; stop lasts StopBitTicks ticks. Frame length = (1+WordLength)*16 + StopBitTicks ticks.
- Cycles without sample_tick_i hold all state. A tick on every clock cycle (tick = clk) must work.
- tx_start_i while busy is ignored: no queueing, no effect on the frame in progress. Changes to din_i during a frame have no effect.
- tx_start_i on the tx_done_tick_o cycle is ignored (state is still STOP). A request held high is accepted on the next cycle (IDLE), giving back-to-back frames with zero idle ticks.
- No other states; the default branch returns to IDLE with tx_o=1.

Test Plan:
1. Reset: assert rst_ni=0 mid-DATA with a tick every 10 clocks -> tx_o=1, busy=0 in the same cycle; no done pulse; after release, IDLE holds tx_o=1 indefinitely.
2. Single frame: defaults, tick every 10 clocks, 1-cycle tx_start_i with din_i=8'hA5 -> tx_o = 0,1,0,1,0,0,1,0,1 then 1, each bit 160 clocks, stop 160 clocks; tx_done_tick_o high exactly one clock, 1600 clocks ± tick phase after start; tx_busy_o low the next cycle.
3. Stop-bit variants: StopBitTicks=24 and 32, din_i=8'h00 -> stop high for 24/32 ticks; total frame 168/176 ticks; done pulse on the last stop tick.
4. WordLength=5, din_i=8'hFF -> only 5 data bits of 1 after start; stop follows tick 96; frame 112 ticks.
5. Busy rejection: while the 8'h3C frame is in DATA, pulse tx_start_i with din_i=8'hFF -> the line still carries 8'h3C; exactly one done pulse; no second frame.
6. Back-to-back and fast tick: sample_tick_i tied to 1, tx_start_i held high with din_i=8'h81 -> frame 160 clocks; second start bit begins 1 clock after the done pulse; tx_busy_o stays high across the boundary except the single IDLE cycle.
